// File: rtl/fp_div_ctrl_if.sv
// rtl/fp_div_ctrl_if.sv - request, result and core-side signals of the FP divide issue stage
interface fp_div_ctrl_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_flags;
    logic        o_core_valid;
    logic [31:0] o_core_a;
    logic [31:0] o_core_b;
    logic        i_core_valid;
    logic [31:0] i_core_result;

    modport slave (
        input  i_valid, i_a, i_b, i_core_valid, i_core_result,
        output o_ready, o_valid, o_result, o_flags, o_core_valid, o_core_a, o_core_b
    );

    modport master (
        output i_valid, i_a, i_b, i_core_valid, i_core_result,
        input  o_ready, o_valid, o_result, o_flags, o_core_valid, o_core_a, o_core_b
    );
endinterface

// File: rtl/fp_div_ctrl.sv
// rtl/fp_div_ctrl.sv - single-precision divide issue stage: classify, launch core, fix exponent, saturate
module fp_div_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input logic           i_clk,
    input logic           i_rst_n,
    fp_div_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_CLASS, S_WAIT, S_FIX, S_DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t           state, state_next;
    logic [31:0]      a_q, b_q;
    logic [30:0]      core_q;
    logic [31:0]      result_q, result_next;
    logic [4:0]       flags_q, flags_next;
    logic [CNT_W-1:0] cnt;
    logic             load_res;
    logic             launch;

    logic [7:0]  a_exp, b_exp, core_exp, d8;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        sign, adj, e_ovf, e_unf;
    logic [9:0]  e_raw;
    logic [31:0] inf_res, zero_res;

    assign a_exp  = a_q[30:23];
    assign b_exp  = b_q[30:23];
    assign a_zero = (a_exp == 8'd0);
    assign b_zero = (b_exp == 8'd0);
    assign a_inf  = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan  = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
    assign sign   = a_q[31] ^ b_q[31];

    assign inf_res  = {sign, 8'hFF, 23'd0};
    assign zero_res = {sign, 31'd0};

    // The core drops one from the exponent when it normalised; detect that by
    // comparing its raw exponent with the plain wrapped difference.
    assign core_exp = core_q[30:23];
    assign d8       = a_exp - b_exp;
    assign adj      = (core_exp != d8);
    assign e_raw    = {2'b00, a_exp} - {2'b00, b_exp} + 10'd127 - {9'd0, adj};
    assign e_ovf    = $signed(e_raw) >= 10'sd255;
    assign e_unf    = $signed(e_raw) <= 10'sd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        result_next = result_q;
        flags_next  = 5'd0;
        load_res    = 1'b0;
        launch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_valid) state_next = S_CLASS;
            end
            S_CLASS: begin
                state_next = S_DONE;
                load_res   = 1'b1;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_next = QNAN;
                    flags_next  = 5'b01000;
                end else if (b_zero) begin
                    result_next = inf_res;
                    flags_next  = 5'b00100;
                end else if (a_inf) begin
                    result_next = inf_res;
                end else if (a_zero || b_inf) begin
                    result_next = zero_res;
                end else begin
                    load_res   = 1'b0;
                    launch     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_core_valid) begin
                    state_next = S_FIX;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    result_next = QNAN;
                    flags_next  = 5'b10000;
                    load_res    = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_FIX: begin
                load_res   = 1'b1;
                state_next = S_DONE;
                if (e_ovf) begin
                    result_next = inf_res;
                    flags_next  = 5'b00010;
                end else if (e_unf) begin
                    result_next = zero_res;
                    flags_next  = 5'b00001;
                end else begin
                    result_next = {sign, e_raw[7:0], core_q[22:0]};
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            core_q   <= 31'd0;
            cnt      <= '0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
        end else begin
            if (state == S_IDLE && bus.i_valid) begin
                a_q <= bus.i_a;
                b_q <= bus.i_b;
            end
            if (launch) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_WAIT && bus.i_core_valid) begin
                core_q <= bus.i_core_result[30:0];
            end
            if (load_res) begin
                result_q <= result_next;
                flags_q  <= flags_next;
            end
        end
    end

    assign bus.o_ready      = (state == S_IDLE);
    assign bus.o_valid      = (state == S_DONE);
    assign bus.o_core_valid = launch;
    assign bus.o_core_a     = a_q;
    assign bus.o_core_b     = b_q;
    assign bus.o_result     = result_q;
    assign bus.o_flags      = flags_q;

endmodule

// File: tb/tb_fp_div_ctrl.sv
// tb/tb_fp_div_ctrl.sv - scoreboard bench for fp_div_ctrl with a behavioural divide core
module tb_fp_div_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_div_ctrl_if bus ();

    fp_div_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_launch = 0;
    logic [36:0] exp_q[$];
    bit core_silent = 1'b0;
    bit core_rand   = 1'b0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endfunction

    // Core emulation: truncated quotient with raw exponent a_exp-b_exp (minus one when a_man < b_man).
    function automatic logic [31:0] core_div(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, q;
        logic [7:0]  raw;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        if (ma >= mb) begin
            q   = (ma << 23) / mb;
            raw = a[30:23] - b[30:23];
        end else begin
            q   = (ma << 24) / mb;
            raw = a[30:23] - b[30:23] - 8'd1;
        end
        return {a[31] ^ b[31], raw, q[22:0]};
    endfunction

    // Reference: IEEE-style classification and an exact-integer quotient of the significands.
    function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e;
        bit s, az, bz, ai, bi, an, bn;
        longint ma, mb, q;
        logic [22:0] f;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {5'b01000, 32'h7FC00000};
        if (bz) return {5'b00100, s, 8'hFF, 23'd0};
        if (ai) return {5'b00000, s, 8'hFF, 23'd0};
        if (az || bi) return {5'b00000, s, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        q  = (ma << 24) / mb;
        if (q >= (64'sd1 << 24)) begin
            e = ea - eb + 127;
            f = q[23:1];
        end else begin
            e = ea - eb + 126;
            f = q[22:0];
        end
        if (e >= 255) return {5'b00010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {5'b00001, s, 31'd0};
        return {5'b00000, s, e[7:0], f};
    endfunction

    initial begin : core_model
        bit pend;
        int cd;
        logic [31:0] ca, cb;
        pend = 1'b0;
        cd = 0;
        ca = 32'd0;
        cb = 32'd0;
        bus.i_core_valid  = 1'b0;
        bus.i_core_result = 32'd0;
        forever begin
            @(negedge clk);
            bus.i_core_valid = 1'b0;
            if (bus.o_core_valid) begin
                n_launch++;
                pend = !core_silent;
                cd   = core_rand ? int'($urandom_range(1, 30)) : 26;
                ca   = bus.o_core_a;
                cb   = bus.o_core_b;
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend = 1'b0;
                    bus.i_core_valid  = 1'b1;
                    bus.i_core_result = core_div(ca, cb);
                    if (!bus.o_ready) chk("core_operands_stable", {bus.o_core_a, bus.o_core_b}, {ca, cb});
                end
            end
        end
    end

    initial begin : monitor
        logic [36:0] e;
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_valid) begin
                n_valid++;
                chk("o_valid_single_cycle", 64'(prev_valid), 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_o_valid: got result %h flags %b want no strobe", bus.o_result, bus.o_flags);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_result", 64'(bus.o_result), 64'(e[31:0]));
                    chk("o_flags", 64'(bus.o_flags), 64'(e[36:32]));
                end
            end
            prev_valid = bus.o_valid;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fl, input logic [31:0] res);
        int k;
        k = 0;
        while (!bus.o_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_issue", 64'(bus.o_ready), 64'd1);
        exp_q.push_back({fl, res});
        bus.i_a = a;
        bus.i_b = b;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !bus.o_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        int r;
        logic [31:0] frac;
        logic [7:0] ex;
        r = int'($urandom_range(0, 19));
        frac = $urandom;
        if (r < 2)       ex = 8'd0;
        else if (r == 2) begin ex = 8'hFF; frac = 32'd0; end
        else if (r == 3) begin ex = 8'hFF; frac = frac | 32'd1; end
        else             ex = 8'($urandom_range(1, 254));
        return {1'($urandom), ex, frac[22:0]};
    endfunction

    initial begin : stim
        int l0, v0;
        logic [36:0] r;
        logic [31:0] a, b;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_a = 32'd0;
        bus.i_b = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_o_ready", 64'(bus.o_ready), 64'd1);
        chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
        chk("reset_o_result", 64'(bus.o_result), 64'd0);
        chk("reset_o_flags", 64'(bus.o_flags), 64'd0);
        chk("reset_o_core_valid", 64'(bus.o_core_valid), 64'd0);
        chk("reset_core_ops", {bus.o_core_a, bus.o_core_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h40C00000, 32'h40000000, 5'b00000, 32'h40400000);
        wait_idle();
        issue(32'h3F800000, 32'h40400000, 5'b00000, 32'h3EAAAAAA);
        wait_idle();

        l0 = n_launch;
        issue(32'h3F800000, 32'h00000000, 5'b00100, 32'h7F800000);
        chk("special_not_yet_valid", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        chk("special_latency", 64'(bus.o_valid), 64'd1);
        wait_idle();
        chk("special_no_launch", 64'(n_launch), 64'(l0));

        issue(32'h00000000, 32'h80000000, 5'b01000, 32'h7FC00000);
        wait_idle();
        issue(32'h7F000000, 32'h3E800000, 5'b00010, 32'h7F800000);
        wait_idle();
        issue(32'h00800000, 32'h4B000000, 5'b00001, 32'h00000000);
        wait_idle();

        core_silent = 1'b1;
        issue(32'h40C00000, 32'h40000000, 5'b10000, 32'h7FC00000);
        wait_idle();
        core_silent = 1'b0;
        issue(32'hC0C00000, 32'h40000000, 5'b00000, 32'hC0400000);
        wait_idle();

        issue(32'h40C00000, 32'h40000000, 5'b00000, 32'h40400000);
        bus.i_a = 32'h3F800000;
        bus.i_b = 32'h00000000;
        bus.i_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("busy_not_ready", 64'(bus.o_ready), 64'd0);
        end
        bus.i_valid = 1'b0;
        wait_idle();

        issue(32'h3F800000, 32'h40400000, 5'b00000, 32'h3EAAAAAA);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_o_ready", 64'(bus.o_ready), 64'd1);
        chk("abort_o_valid", 64'(bus.o_valid), 64'd0);
        chk("abort_o_result", 64'(bus.o_result), 64'd0);
        chk("abort_o_flags", 64'(bus.o_flags), 64'd0);
        chk("abort_core_ops", {bus.o_core_a, bus.o_core_b}, 64'd0);
        exp_q.delete();
        v0 = n_valid;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("stale_core_done_ignored", 64'(n_valid), 64'(v0));

        core_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            r = ref_div(a, b);
            issue(a, b, r[36:32], r[31:0]);
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no completion want $finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
